ram_write_arbiter: RTL and testbench

- Round-robin arbiter that shares the single write port of the ping-pong sample buffer (ram_logic) between NUM_REQ sample producers, e.g. microphone channels.
- Registers the winning sample into a one-entry output stage that drives the buffer's valid/ready write interface, and emits the source channel ID alongside it.
- Re-aligns arbitration to requester 0 on every buffer swap, so each buffer starts with channel 0.

---
 rtl/ram_pkg.sv | 41 ++++
 rtl/ram_write_arbiter_if.sv | 32 +++
 rtl/rr_arbiter.sv | 32 +++
 rtl/ram_write_arbiter.sv | 114 +++++++++++
 tb/tb_ram_write_arbiter.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_pkg.sv
// Purpose : shared types and the round-robin pick helper for the ping-pong sample buffer arbiters.
// Latency : n/a (types, constants and a pure function only).
// Backpr. : n/a.
// Contents: SAMPLE_W default sample width, sample_t, state_e (output stage FSM), rr_pick_t, rr_pick().
package ram_pkg;

  localparam int SAMPLE_W = 32;
  // Upper bound on requesters; rr_pick works on a fixed-width view of the request vector.
  localparam int MAX_REQ  = 8;

  typedef logic signed [SAMPLE_W-1:0] sample_t;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } state_e;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } rr_pick_t;

  // First set bit of valid[n-1:0], scanning ptr, ptr+1, ... modulo n.
  function automatic rr_pick_t rr_pick(input logic [MAX_REQ-1:0] valid,
                                       input logic [2:0]         ptr,
                                       input int                 n);
    rr_pick_t res;
    int       k;
    res = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      k = int'(ptr) + i;
      if (k >= n) k = k - n;
      if (i < n && !res.found && valid[k[2:0]]) begin
        res.found = 1'b1;
        res.idx   = k[2:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ram_write_arbiter_if.sv
// Purpose : request/write-port bundle between NUM_REQ sample producers, the arbiter and the buffer write port.
// Latency : n/a (wires only).
// Backpr. : req_ready_o back-pressures producers; wr_ready_i back-pressures the arbiter output stage.
// Modports: master = arbiter side (drives req_ready_o, wr_*_o); slave = producers + buffer side.
interface ram_write_arbiter_if
  import ram_pkg::*;
#(
  parameter  int WIDTH   = SAMPLE_W,
  parameter  int NUM_REQ = 4,
  localparam int CH_W    = $clog2(NUM_REQ)
);

  logic [NUM_REQ*WIDTH-1:0] req_data_i;
  logic [NUM_REQ-1:0]       req_valid_i;
  logic [NUM_REQ-1:0]       req_ready_o;
  logic signed [WIDTH-1:0]  wr_data_o;
  logic                     wr_valid_o;
  logic                     wr_ready_i;
  logic [CH_W-1:0]          wr_ch_o;
  logic                     buffer_ready_i;

  modport master (
    input  req_data_i, req_valid_i, wr_ready_i, buffer_ready_i,
    output req_ready_o, wr_data_o, wr_valid_o, wr_ch_o
  );

  modport slave (
    output req_data_i, req_valid_i, wr_ready_i, buffer_ready_i,
    input  req_ready_o, wr_data_o, wr_valid_o, wr_ch_o
  );

endinterface

// File: rtl/rr_arbiter.sv
// Purpose : combinational round-robin priority rotation starting at ptr_i; shared by write and read sides.
// Latency : 0 cycles (purely combinational).
// Backpr. : none; caller qualifies gnt_o with its own load condition.
// Ports   : req_i requests, ptr_i first index to scan, gnt_o one-hot grant, idx_o winner index, vld_o any request.
module rr_arbiter
  import ram_pkg::*;
#(
  parameter  int NUM_REQ = 4,
  localparam int CH_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req_i,
  input  logic [CH_W-1:0]    ptr_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [CH_W-1:0]    idx_o,
  output logic               vld_o
);

  logic [MAX_REQ-1:0] req_ext;
  rr_pick_t           pick;

  always_comb begin
    req_ext                = '0;
    req_ext[NUM_REQ-1:0]   = req_i;
    pick                   = rr_pick(req_ext, 3'(ptr_i), NUM_REQ);
    idx_o                  = pick.idx[CH_W-1:0];
    vld_o                  = pick.found;
    for (int k = 0; k < NUM_REQ; k++) begin
      gnt_o[k] = pick.found && (int'(pick.idx) == k);
    end
  end

endmodule

// File: rtl/ram_write_arbiter.sv
// Purpose : round-robin share of the ping-pong buffer write port between NUM_REQ producers, with channel ID.
// Latency : 1 cycle from req handshake to wr_valid_o; 1 sample/cycle sustained while wr_ready_i=1.
// Backpr. : wr_ready_i=0 while FULL stalls all requesters (req_ready_o=0); output holds stable, nothing dropped.
// Ports   : clk_i, rst_ni (async active-low), bus (ram_write_arbiter_if.master),
//           grant_cnt_o [NUM_REQ*16] per-requester grant counts, present only with RAM_ARB_GRANT_CNT_EN.
module ram_write_arbiter
  import ram_pkg::*;
#(
  parameter  int WIDTH   = SAMPLE_W,
  parameter  int NUM_REQ = 4,
  localparam int CH_W    = $clog2(NUM_REQ)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  ram_write_arbiter_if.master   bus
`ifdef RAM_ARB_GRANT_CNT_EN
  ,
  output logic [NUM_REQ*16-1:0] grant_cnt_o
`endif
);

  state_e                  state_q, state_d;
  logic signed [WIDTH-1:0] data_q, data_d;
  logic [CH_W-1:0]         ch_q, ch_d;
  logic [CH_W-1:0]         ptr_q, ptr_d;

  logic [NUM_REQ-1:0]      arb_gnt;
  logic [CH_W-1:0]         arb_idx;
  logic                    arb_vld;
  logic                    load_en;
  logic                    grant;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req_i (bus.req_valid_i),
    .ptr_i (ptr_q),
    .gnt_o (arb_gnt),
    .idx_o (arb_idx),
    .vld_o (arb_vld)
  );

  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    ch_d    = ch_q;
    ptr_d   = ptr_q;
    load_en = (state_q == ST_EMPTY) || bus.wr_ready_i;
    // rst_ni gating keeps req_ready_o low while reset is held, even though state_q already reads EMPTY.
    grant   = load_en && arb_vld && rst_ni;

    if (grant) begin
      state_d = ST_FULL;
      data_d  = bus.req_data_i[arb_idx*WIDTH +: WIDTH];
      ch_d    = arb_idx;
      ptr_d   = (arb_idx == CH_W'(NUM_REQ-1)) ? '0 : arb_idx + 1'b1;
    end else if (state_q == ST_FULL && bus.wr_ready_i) begin
      state_d = ST_EMPTY;
    end

    // A buffer swap realigns to channel 0; the grant in the same cycle already used the old pointer.
    if (bus.buffer_ready_i) begin
      ptr_d = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= ST_EMPTY;
      data_q  <= '0;
      ch_q    <= '0;
      ptr_q   <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      ch_q    <= ch_d;
      ptr_q   <= ptr_d;
    end
  end

  assign bus.req_ready_o = grant ? arb_gnt : '0;
  assign bus.wr_valid_o  = (state_q == ST_FULL);
  assign bus.wr_data_o   = data_q;
  assign bus.wr_ch_o     = ch_q;

`ifdef RAM_ARB_GRANT_CNT_EN
  logic [15:0] cnt_q [NUM_REQ];
  logic [15:0] cnt_d [NUM_REQ];

  // Counts restart per buffer; a grant in the swap cycle belongs to the new buffer, hence the load of 1.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) begin
      cnt_d[k] = cnt_q[k];
      if (bus.buffer_ready_i) begin
        cnt_d[k] = (grant && int'(arb_idx) == k) ? 16'd1 : 16'd0;
      end else if (grant && int'(arb_idx) == k && cnt_q[k] != 16'hFFFF) begin
        cnt_d[k] = cnt_q[k] + 16'd1;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= '0;
    end else begin
      for (int k = 0; k < NUM_REQ; k++) cnt_q[k] <= cnt_d[k];
    end
  end

  always_comb begin
    grant_cnt_o = '0;
    for (int k = 0; k < NUM_REQ; k++) grant_cnt_o[k*16 +: 16] = cnt_q[k];
  end
`endif

endmodule

// File: tb/tb_ram_write_arbiter.sv
// Purpose : self-checking bench for ram_write_arbiter: vector table, corner sequences, randomized run vs model.
// Latency : n/a.
// Backpr. : wr_ready_i driven low in bursts and at random to exercise hold behaviour.
module tb_ram_write_arbiter;
  import ram_pkg::*;

  localparam int W = 32;
  localparam int N = 4;

  logic clk_i;
  logic rst_ni;
  int   checks = 0;
  int   errors = 0;

  ram_write_arbiter_if #(.WIDTH(W), .NUM_REQ(N)) bus_if ();

`ifdef RAM_ARB_GRANT_CNT_EN
  logic [N*16-1:0] grant_cnt;
`endif

  ram_write_arbiter #(.WIDTH(W), .NUM_REQ(N)) dut (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .bus    (bus_if)
`ifdef RAM_ARB_GRANT_CNT_EN
    ,
    .grant_cnt_o (grant_cnt)
`endif
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h @%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  typedef struct {
    int      ch;
    sample_t d;
  } sb_t;

  bit      m_full;
  sample_t m_data;
  int      m_ch;
  int      m_ptr;
  int      m_cnt [N];
  sb_t     sb [$];

  function automatic int pick(input logic [N-1:0] v, input int ptr);
    for (int i = 0; i < N; i++) begin
      if (v[(ptr + i) % N]) return (ptr + i) % N;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_full = 0;
    m_data = '0;
    m_ch   = 0;
    m_ptr  = 0;
    for (int k = 0; k < N; k++) m_cnt[k] = 0;
    sb.delete();
  endtask

  // Called at the negedge: check DUT against the model, then advance the model across the coming posedge.
  task automatic model_step();
    int          w;
    logic [N-1:0] exp_rdy;
    sb_t         s;
    w = (!m_full || bus_if.wr_ready_i) ? pick(bus_if.req_valid_i, m_ptr) : -1;
    exp_rdy = '0;
    if (w >= 0) exp_rdy[w] = 1'b1;
    chk("req_ready", bus_if.req_ready_o, exp_rdy);
    chk("wr_valid", bus_if.wr_valid_o, m_full);
    if (m_full) begin
      chk("wr_ch", bus_if.wr_ch_o, m_ch);
      chk("wr_data", bus_if.wr_data_o, m_data);
    end
`ifdef RAM_ARB_GRANT_CNT_EN
    begin
      logic [N*16-1:0] e;
      for (int k = 0; k < N; k++) e[k*16 +: 16] = 16'(m_cnt[k]);
      chk("grant_cnt", grant_cnt, e);
    end
`endif
    // Ordered scoreboard built from observed handshakes only.
    if (bus_if.wr_valid_o && bus_if.wr_ready_i) begin
      if (sb.size() == 0) chk("sb_underflow", 1, 0);
      else begin
        s = sb.pop_front();
        chk("sb_ch", bus_if.wr_ch_o, s.ch);
        chk("sb_data", bus_if.wr_data_o, s.d);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (bus_if.req_ready_o[k] && bus_if.req_valid_i[k])
        sb.push_back('{k, sample_t'(bus_if.req_data_i[k*W +: W])});
    end
    // Advance model.
    if (w >= 0) begin
      m_full = 1;
      m_ch   = w;
      m_data = bus_if.req_data_i[w*W +: W];
      m_ptr  = (w + 1) % N;
    end else if (m_full && bus_if.wr_ready_i) begin
      m_full = 0;
    end
    if (bus_if.buffer_ready_i) begin
      m_ptr = 0;
      for (int k = 0; k < N; k++) m_cnt[k] = 0;
      if (w >= 0) m_cnt[w] = 1;
    end else if (w >= 0 && m_cnt[w] < 65535) begin
      m_cnt[w]++;
    end
  endtask

  task automatic cyc();
    @(negedge clk_i);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic cyc_exp(input logic [N-1:0] e, input string nm);
    @(negedge clk_i);
    chk(nm, bus_if.req_ready_o, e);
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic set_in(input logic [N-1:0] v, input logic rdy, input logic br);
    bus_if.req_valid_i    = v;
    bus_if.wr_ready_i     = rdy;
    bus_if.buffer_ready_i = br;
  endtask

  task automatic do_reset();
    rst_ni = 1'b0;
    set_in('0, 1'b0, 1'b0);
    repeat (2) @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic [N-1:0] v;
    logic         rdy;
    logic         br;
    logic [N-1:0] exp_rr;
    logic         exp_vld;
    int           exp_ch;
  } vec_t;

  vec_t    tbl [18];
  sample_t tdat [N];

  initial begin
    tdat[0] = 32'shA000_0000;
    tdat[1] = 32'sh0000_0011;
    tdat[2] = 32'sh0000_1234;
    tdat[3] = 32'sh7FFF_FFFF;
    // Each row: inputs for one cycle, expected outputs seen before that cycle's edge.
    tbl[0]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b0, 0};
    tbl[1]  = '{4'b1111, 1'b1, 1'b0, 4'b0010, 1'b1, 0};
    tbl[2]  = '{4'b1111, 1'b1, 1'b0, 4'b0100, 1'b1, 1};
    tbl[3]  = '{4'b1111, 1'b1, 1'b0, 4'b1000, 1'b1, 2};
    tbl[4]  = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 3};
    tbl[5]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 0};
    tbl[6]  = '{4'b0100, 1'b1, 1'b0, 4'b0100, 1'b1, 2};
    tbl[7]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 2};
    tbl[8]  = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b0, 0};
    tbl[9]  = '{4'b1111, 1'b0, 1'b0, 4'b1000, 1'b0, 0};
    tbl[10] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 3};
    tbl[11] = '{4'b1111, 1'b0, 1'b0, 4'b0000, 1'b1, 3};
    tbl[12] = '{4'b1111, 1'b1, 1'b1, 4'b0001, 1'b1, 3};
    tbl[13] = '{4'b1111, 1'b1, 1'b0, 4'b0001, 1'b1, 0};
    tbl[14] = '{4'b0011, 1'b1, 1'b0, 4'b0010, 1'b1, 0};
    tbl[15] = '{4'b0011, 1'b1, 1'b0, 4'b0001, 1'b1, 1};
    tbl[16] = '{4'b0000, 1'b1, 1'b0, 4'b0000, 1'b1, 0};
    tbl[17] = '{4'b0000, 1'b0, 1'b0, 4'b0000, 1'b0, 0};

    // ---- reset state, requests already valid to prove ready is held low ----
    rst_ni = 1'b0;
    for (int k = 0; k < N; k++) bus_if.req_data_i[k*W +: W] = tdat[k];
    set_in(4'b1111, 1'b1, 1'b0);
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_wr_valid", bus_if.wr_valid_o, 0);
    chk("rst_wr_ch", bus_if.wr_ch_o, 0);
    chk("rst_wr_data", bus_if.wr_data_o, 0);
    chk("rst_req_ready", bus_if.req_ready_o, 0);
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;

    // ---- table ----
    for (int i = 0; i < 18; i++) begin
      set_in(tbl[i].v, tbl[i].rdy, tbl[i].br);
      @(negedge clk_i);
      chk($sformatf("tbl%0d_req_ready", i), bus_if.req_ready_o, tbl[i].exp_rr);
      chk($sformatf("tbl%0d_wr_valid", i), bus_if.wr_valid_o, tbl[i].exp_vld);
      if (tbl[i].exp_vld) begin
        chk($sformatf("tbl%0d_wr_ch", i), bus_if.wr_ch_o, tbl[i].exp_ch);
        chk($sformatf("tbl%0d_wr_data", i), bus_if.wr_data_o, tdat[tbl[i].exp_ch]);
      end
      @(posedge clk_i);
      #1;
    end

    // ---- swap with pointer at 3: current grant ch3, next ch0, then ch1 ----
    do_reset();
    set_in(4'b1111, 1'b1, 1'b0);
    repeat (3) cyc();
    set_in(4'b1111, 1'b1, 1'b1);
    cyc_exp(4'b1000, "swap_cur_grant");
    set_in(4'b1111, 1'b1, 1'b0);
    cyc_exp(4'b0001, "swap_next_grant");
    cyc_exp(4'b0010, "swap_after_next");

    // ---- back-pressure for 5 cycles while FULL, then resume in pointer order ----
    set_in(4'b1111, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) cyc_exp(4'b0000, "hold_req_ready");
    set_in(4'b1111, 1'b1, 1'b0);
    cyc_exp(4'b0100, "hold_release_grant");
    set_in(4'b0000, 1'b1, 1'b0);
    repeat (2) cyc();
    chk("hold_sb_empty", sb.size(), 0);

    // ---- async reset while FULL ----
    set_in(4'b1111, 1'b0, 1'b0);
    repeat (2) cyc();
    chk("pre_reset_full", bus_if.wr_valid_o, 1);
    rst_ni = 1'b0;
    #1;
    chk("async_rst_wr_valid", bus_if.wr_valid_o, 0);
    chk("async_rst_req_ready", bus_if.req_ready_o, 0);
    model_reset();
    @(posedge clk_i);
    #1;
    rst_ni = 1'b1;
    set_in(4'b1111, 1'b1, 1'b0);
    cyc_exp(4'b0001, "post_reset_grant");
    cyc();

`ifdef RAM_ARB_GRANT_CNT_EN
    // ---- grant counters: 10 all-valid grants, then a swap clears them ----
    do_reset();
    set_in(4'b1111, 1'b1, 1'b0);
    repeat (10) cyc();
    set_in(4'b0000, 1'b1, 1'b1);
    @(negedge clk_i);
    chk("cnt_before_clear", grant_cnt, {16'd2, 16'd2, 16'd3, 16'd3});
    model_step();
    @(posedge clk_i);
    #1;
    set_in(4'b0000, 1'b1, 1'b0);
    @(negedge clk_i);
    chk("cnt_after_clear", grant_cnt, 64'd0);
    model_step();
    @(posedge clk_i);
    #1;
`endif

    // ---- randomized run against the model ----
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < N; k++) bus_if.req_data_i[k*W +: W] = $urandom;
      bus_if.req_valid_i    = N'($urandom);
      bus_if.wr_ready_i     = ((i % 200) < 15) ? 1'b0 : ($urandom_range(0, 3) != 0);
      bus_if.buffer_ready_i = ($urandom_range(0, 15) == 0);
      cyc();
    end
    set_in(4'b0000, 1'b1, 1'b0);
    repeat (2) cyc();
    chk("rand_sb_empty", sb.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
